bg_axil_shadow_regs: RTL

- Parametrised AXI4-Lite slave register bank for the background manager; next generation of the fixed 4-register peripheral.
- Register count, data width and read-only map are parameters; WSTRB is supported; out-of-range and read-only writes return SLVERR.
- Software writes land in shadow registers. The active copy driving the background renderer updates only at a frame boundary (frame_sync), so scroll/tile settings never tear mid-frame.

---
 rtl/bg_regs_pkg.sv | 24 ++
 rtl/bg_shadow_commit.sv | 102 ++++++++++
 rtl/bg_axil_shadow_regs.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/bg_regs_pkg.sv
// Shared constants, types and address-decode helpers for the background
// manager AXI4-Lite shadow register bank.
package bg_regs_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int CTRL_COMMIT_BIT = 0;
    localparam int CTRL_AUTO_BIT   = 1;

    typedef enum logic [0:0] {
        WR_IDLE = 1'b0,
        WR_RESP = 1'b1
    } wr_state_t;

    function automatic logic [63:0] addr_to_index(input logic [63:0] addr, input int unsigned lsb);
        return addr >> lsb;
    endfunction

    function automatic logic index_in_range(input logic [63:0] idx, input int unsigned num_regs);
        return idx < 64'(num_regs);
    endfunction

endpackage

// File: rtl/bg_shadow_commit.sv
// Shadow/active register arrays with byte-strobe merge and the frame-synchronous
// commit mechanism. Slot 0 of both buses carries the control register image.
module bg_shadow_commit #(
    parameter int                    DW       = 32,
    parameter int                    NUM_REGS = 16,
    parameter int                    IDX_W    = 4,
    parameter logic [NUM_REGS-1:0]   RO_MASK  = {NUM_REGS{1'b0}}
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_wr_en,
    input  logic [IDX_W-1:0]       i_wr_idx,
    input  logic [DW-1:0]          i_wr_data,
    input  logic [DW/8-1:0]        i_wr_strb,
    input  logic                   i_frame_sync,
    output logic [NUM_REGS*DW-1:0] o_shadow,
    output logic [NUM_REGS*DW-1:0] o_active,
    output logic                   o_commit_done
);
    import bg_regs_pkg::*;

    logic [DW-1:0] r_shadow [NUM_REGS];
    logic [DW-1:0] r_active [NUM_REGS];
    logic          r_pending;
    logic          r_auto;
    logic          r_commit_done;
    logic [DW-1:0] w_merged;
    logic [DW-1:0] w_ctrl;
    logic          w_ctrl_wr;
    logic          w_commit_wr;
    logic          w_commit;

    assign w_ctrl_wr   = i_wr_en && (i_wr_idx == {IDX_W{1'b0}}) && i_wr_strb[0];
    assign w_commit_wr = w_ctrl_wr && i_wr_data[CTRL_COMMIT_BIT];
    // Commit decision uses pre-write state, so a COMMIT landing on frame_sync waits a frame.
    assign w_commit    = i_frame_sync && (r_pending || r_auto);

    // Byte-lane merge of write data into the addressed shadow register.
    always_comb begin
        w_merged = r_shadow[i_wr_idx];
        for (int b = 0; b < DW/8; b++) begin
            if (i_wr_strb[b]) begin
                w_merged[b*8 +: 8] = i_wr_data[b*8 +: 8];
            end else begin
                w_merged[b*8 +: 8] = r_shadow[i_wr_idx][b*8 +: 8];
            end
        end
    end

    // Control register read image.
    always_comb begin
        w_ctrl                  = {DW{1'b0}};
        w_ctrl[CTRL_COMMIT_BIT] = r_pending;
        w_ctrl[CTRL_AUTO_BIT]   = r_auto;
    end

    // Shadow writes, control bits and commit into the active copy.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_shadow[i] <= {DW{1'b0}};
                r_active[i] <= {DW{1'b0}};
            end
            r_pending     <= 1'b0;
            r_auto        <= 1'b0;
            r_commit_done <= 1'b0;
        end else begin
            r_commit_done <= w_commit;
            if (w_commit_wr) begin
                r_pending <= 1'b1;
            end else if (w_commit) begin
                r_pending <= 1'b0;
            end
            if (w_ctrl_wr) begin
                r_auto <= i_wr_data[CTRL_AUTO_BIT];
            end
            if (i_wr_en && (i_wr_idx != {IDX_W{1'b0}})) begin
                r_shadow[i_wr_idx] <= w_merged;
            end
            if (w_commit) begin
                for (int i = 1; i < NUM_REGS; i++) begin
                    if (!RO_MASK[i]) begin
                        r_active[i] <= r_shadow[i];
                    end
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_pack
        if (gi == 0) begin : g_ctrl
            assign o_shadow[gi*DW +: DW] = w_ctrl;
            assign o_active[gi*DW +: DW] = w_ctrl;
        end else begin : g_reg
            assign o_shadow[gi*DW +: DW] = r_shadow[gi];
            assign o_active[gi*DW +: DW] = r_active[gi];
        end
    end

    assign o_commit_done = r_commit_done;

endmodule

// File: rtl/bg_axil_shadow_regs.sv
// AXI4-Lite slave front end for the background manager register bank; writes
// land in shadow registers that are committed to the renderer on frame_sync.
module bg_axil_shadow_regs #(
    parameter int                  C_S_AXI_DATA_WIDTH = 32,
    parameter int                  C_S_AXI_ADDR_WIDTH = 6,
    parameter int                  NUM_REGS           = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK            = {NUM_REGS{1'b0}}
) (
    input  logic                                   S_AXI_ACLK,
    input  logic                                   S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [1:0]                             S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    input  logic                                   frame_sync,
    input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] status_in,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regs_active,
    output logic                                   commit_done
);
    import bg_regs_pkg::*;

    localparam int          DW       = C_S_AXI_DATA_WIDTH;
    localparam int          AW       = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned ADDR_LSB = (DW == 64) ? 3 : 2;
    localparam int          IDX_W    = $clog2(NUM_REGS);

    wr_state_t               r_wr_state;
    wr_state_t               w_wr_next;
    logic                    w_wr_exec;
    logic                    r_awready;
    logic                    r_wready;
    logic                    r_bvalid;
    logic [1:0]              r_bresp;
    logic [AW-1:0]           r_awaddr;
    logic [DW-1:0]           r_wdata;
    logic [DW/8-1:0]         r_wstrb;
    logic                    r_arready;
    logic                    r_rvalid;
    logic [1:0]              r_rresp;
    logic [DW-1:0]           r_rdata;
    logic [63:0]             w_wr_idx_full;
    logic [63:0]             w_rd_idx_full;
    logic [IDX_W-1:0]        w_wr_idx;
    logic [IDX_W-1:0]        w_rd_idx;
    logic                    w_wr_ok;
    logic                    w_rd_inr;
    logic                    w_rd_ro;
    logic [DW-1:0]           w_rd_data;
    logic [NUM_REGS*DW-1:0]  w_shadow;
    logic                    w_unused;

    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    assign w_wr_idx_full = addr_to_index(64'(r_awaddr), ADDR_LSB);
    assign w_wr_idx      = w_wr_idx_full[IDX_W-1:0];
    assign w_wr_ok       = index_in_range(w_wr_idx_full, NUM_REGS)
                           && !((w_wr_idx != {IDX_W{1'b0}}) && RO_MASK[w_wr_idx]);

    assign w_rd_idx_full = addr_to_index(64'(S_AXI_ARADDR), ADDR_LSB);
    assign w_rd_idx      = w_rd_idx_full[IDX_W-1:0];
    assign w_rd_inr      = index_in_range(w_rd_idx_full, NUM_REGS);
    assign w_rd_ro       = (w_rd_idx != {IDX_W{1'b0}}) && RO_MASK[w_rd_idx];

    // Write FSM: execute once both AW and W are held, then wait out the B handshake.
    always_comb begin
        w_wr_next = r_wr_state;
        w_wr_exec = 1'b0;
        case (r_wr_state)
            WR_IDLE: begin
                if (!r_awready && !r_wready) begin
                    w_wr_exec = 1'b1;
                    w_wr_next = WR_RESP;
                end else begin
                    w_wr_next = WR_IDLE;
                end
            end
            WR_RESP: begin
                if (S_AXI_BREADY) begin
                    w_wr_next = WR_IDLE;
                end else begin
                    w_wr_next = WR_RESP;
                end
            end
            default: w_wr_next = WR_IDLE;
        endcase
    end

    // Write FSM state register.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_wr_state <= WR_IDLE;
        end else begin
            r_wr_state <= w_wr_next;
        end
    end

    // AW/W capture and B channel.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_awaddr  <= {AW{1'b0}};
            r_wdata   <= {DW{1'b0}};
            r_wstrb   <= {(DW/8){1'b0}};
        end else begin
            if (r_awready && S_AXI_AWVALID) begin
                r_awready <= 1'b0;
                r_awaddr  <= S_AXI_AWADDR;
            end
            if (r_wready && S_AXI_WVALID) begin
                r_wready <= 1'b0;
                r_wdata  <= S_AXI_WDATA;
                r_wstrb  <= S_AXI_WSTRB;
            end
            if (w_wr_exec) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (r_bvalid && S_AXI_BREADY) begin
                r_bvalid  <= 1'b0;
                r_awready <= 1'b1;
                r_wready  <= 1'b1;
            end
        end
    end

    // Read source select; read-only registers return the live status input.
    always_comb begin
        w_rd_data = {DW{1'b0}};
        if (!w_rd_inr) begin
            w_rd_data = {DW{1'b0}};
        end else if (w_rd_ro) begin
            w_rd_data = status_in[w_rd_idx*DW +: DW];
        end else begin
            w_rd_data = w_shadow[w_rd_idx*DW +: DW];
        end
    end

    // AR/R channel: data is captured at the AR handshake.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= {DW{1'b0}};
        end else begin
            if (r_arready && S_AXI_ARVALID) begin
                r_arready <= 1'b0;
                r_rvalid  <= 1'b1;
                r_rdata   <= w_rd_data;
                r_rresp   <= w_rd_inr ? RESP_OKAY : RESP_SLVERR;
            end else if (r_rvalid && S_AXI_RREADY) begin
                r_rvalid  <= 1'b0;
                r_arready <= 1'b1;
            end
        end
    end

    bg_shadow_commit #(
        .DW       (DW),
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W),
        .RO_MASK  (RO_MASK)
    ) u_shadow_commit (
        .i_clk         (S_AXI_ACLK),
        .i_rst         (S_AXI_ARESET),
        .i_wr_en       (w_wr_exec && w_wr_ok),
        .i_wr_idx      (w_wr_idx),
        .i_wr_data     (r_wdata),
        .i_wr_strb     (r_wstrb),
        .i_frame_sync  (frame_sync),
        .o_shadow      (w_shadow),
        .o_active      (regs_active),
        .o_commit_done (commit_done)
    );

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RRESP   = r_rresp;
    assign S_AXI_RDATA   = r_rdata;

endmodule
